// File: rtl/median_pkg.sv
// Shared constants, helpers and the pixel type for the median filter core.
package median_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 8;
    localparam int DEFAULT_KERNEL_SIZE = 5;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] pixel_t;

    function automatic int kernel_taps(input int k);
        return k * k;
    endfunction

    function automatic int median_index(input int k);
        return (k * k - 1) / 2;
    endfunction

endpackage

// File: rtl/median_cmp_swap.sv
// Combinational compare-exchange: smaller value on lo, larger on hi (unsigned).
module median_cmp_swap
    import median_pkg::*;
#(
    parameter int WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    logic swap;

    // Equal values leave the pair untouched.
    assign swap = (b < a);
    assign lo   = swap ? b : a;
    assign hi   = swap ? a : b;

endmodule

// File: rtl/median_filter_core.sv
// Pipelined odd-even transposition median selector with frame/line markers.
// Optional MEDIAN_MINMAX_EN adds o_min/o_max taken from the final sorted lanes.
module median_filter_core
    import median_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int KERNEL_SIZE = DEFAULT_KERNEL_SIZE
) (
    input  logic                  i_clk,
    input  logic                  i_aresetn,
    input  logic [11:0]           IMAGE_WIDTH,
    input  logic [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1][DATA_WIDTH-1:0] i_image_kernel_buffer,
    input  logic                  i_data_valid,
    input  logic                  i_start_of_frame,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_valid,
    output logic                  o_start_of_frame,
    output logic                  o_end_of_line
`ifdef MEDIAN_MINMAX_EN
    ,
    output logic [DATA_WIDTH-1:0] o_min,
    output logic [DATA_WIDTH-1:0] o_max
`endif
);

    localparam int N   = kernel_taps(KERNEL_SIZE);
    localparam int MID = median_index(KERNEL_SIZE);

    logic [N-1:0][DATA_WIDTH-1:0] flat_in;
    logic [N-1:0][DATA_WIDTH-1:0] stage_d [0:N-1];
    logic [N-1:0][DATA_WIDTH-1:0] lane_q  [0:N-1];
    logic [N-1:0]                 valid_q;
    logic [N-1:0]                 sof_q;
    logic [N-1:0]                 stage_en;
    logic [11:0]                  col_q;
    logic [11:0]                  col_base;
    logic                         at_eol;
    logic                         eol_q;
    logic [N-1:0]                 unused_lane_xor;

    for (genvar i = 0; i < N; i++) begin : g_flat
        assign flat_in[i] = i_image_kernel_buffer[i / KERNEL_SIZE][i % KERNEL_SIZE];
    end

    for (genvar s = 0; s < N; s++) begin : g_stage
        logic [N-1:0][DATA_WIDTH-1:0] src;
        logic [N-1:0][DATA_WIDTH-1:0] dst;

        if (s == 0) begin : g_first
            assign src = flat_in;
        end else begin : g_next
            assign src = lane_q[s-1];
        end

        // Even stages pair (0,1),(2,3)...; odd stages pair (1,2),(3,4)...
        for (genvar i = 0; i < N; i++) begin : g_lane
            if (((i % 2) == (s % 2)) && (i + 1 < N)) begin : g_pair
                median_cmp_swap #(.WIDTH(DATA_WIDTH)) u_cx (
                    .a  (src[i]),
                    .b  (src[i+1]),
                    .lo (dst[i]),
                    .hi (dst[i+1])
                );
            end else if ((i == 0) || (((i - 1) % 2) != (s % 2))) begin : g_pass
                assign dst[i] = src[i];
            end
        end

        assign stage_d[s] = dst;
    end

    // A stage captures new data only when the window it receives is valid.
    assign stage_en = {valid_q[N-2:0], i_data_valid};

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            for (int s = 0; s < N; s++) begin
                lane_q[s] <= '0;
            end
            valid_q <= '0;
            sof_q   <= '0;
        end else begin
            for (int s = 0; s < N; s++) begin
                if (stage_en[s]) begin
                    lane_q[s] <= stage_d[s];
                end
            end
            valid_q <= {valid_q[N-2:0], i_data_valid};
            sof_q   <= {sof_q[N-2:0], i_start_of_frame & i_data_valid};
        end
    end

    // The column counter looks one stage ahead so o_end_of_line is registered with the data.
    assign col_base = sof_q[N-2] ? 12'd0 : col_q;
    assign at_eol   = (IMAGE_WIDTH != 12'd0) && (col_base == IMAGE_WIDTH - 12'd1);

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            col_q <= '0;
            eol_q <= 1'b0;
        end else begin
            eol_q <= valid_q[N-2] & at_eol;
            if (valid_q[N-2]) begin
                col_q <= at_eol ? 12'd0 : col_base + 12'd1;
            end
        end
    end

    assign o_data           = lane_q[N-1][MID];
    assign o_data_valid     = valid_q[N-1];
    assign o_start_of_frame = sof_q[N-1];
    assign o_end_of_line    = eol_q;

`ifdef MEDIAN_MINMAX_EN
    assign o_min = lane_q[N-1][0];
    assign o_max = lane_q[N-1][N-1];
`endif

    // Final-stage lanes that feed no output are otherwise dangling.
    for (genvar i = 0; i < N; i++) begin : g_unused
        assign unused_lane_xor[i] = ^lane_q[N-1][i];
    end

endmodule
